// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcodes, FSM states and ALU select mapping for alu_seq
package alu_seq_pkg;
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_NOT = 3'd5;
  localparam logic [2:0] OP_LDI = 3'd6;
  localparam logic [2:0] OP_RSV = 3'd7;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  // {sub, fas, and, or, xor, not}
  function automatic logic [5:0] op_sel(input logic [2:0] op);
    return op == OP_ADD ? 6'b010000 :
           op == OP_SUB ? 6'b110000 :
           op == OP_AND ? 6'b001000 :
           op == OP_OR  ? 6'b000100 :
           op == OP_XOR ? 6'b000010 :
           op == OP_NOT ? 6'b000001 : 6'b000000;
  endfunction
endpackage

// File: rtl/alu_seq_regfile.sv
// alu_seq_regfile: NREG x 16 register file, two async reads, one sync write
module alu_seq_regfile #(
  parameter int NREG = 4,
  localparam int AW = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [15:0]   wd,
  input  logic [AW-1:0] ra,
  input  logic [AW-1:0] rb,
  output logic [15:0]   rda,
  output logic [15:0]   rdb
);
  logic [15:0] r [NREG];
  always_ff @(posedge clk)
    if (rst) r <= '{default: '0};
    else if (we) r[wa] <= wd;
  always_comb begin
    rda = r[ra];
    rdb = r[rb];
  end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: command sequencer driving the ripple ALU select-line interface
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int NREG = 4,
  localparam int AW = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [AW-1:0] cmd_rd,
  input  logic [AW-1:0] cmd_ra,
  input  logic [AW-1:0] cmd_rb,
  input  logic [15:0]   cmd_imm,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [15:0]   rsp_data,
  output logic [2:0]    rsp_flags,
  output logic          rsp_err,
  output logic [15:0]   alu_a,
  output logic [15:0]   alu_b,
  output logic          alu_s_sub,
  output logic          alu_s_fas,
  output logic          alu_s_and,
  output logic          alu_s_or,
  output logic          alu_s_xor,
  output logic          alu_s_not,
  input  logic [15:0]   alu_r,
  input  logic          alu_cout
);
  state_t        state;
  logic [2:0]    op;
  logic [AW-1:0] rd, ra, rb;
  logic [15:0]   imm, rda, rdb, res;
  logic          exec, rsv, we, c;
  alu_seq_regfile #(.NREG(NREG)) u_rf (
    .clk(clk), .rst(rst), .we(we), .wa(rd), .wd(res),
    .ra(ra), .rb(rb), .rda(rda), .rdb(rdb)
  );
  always_comb begin
    exec = state == EXEC;
    rsv = op == OP_RSV;
    we = exec && !rsv;
    cmd_ready = state == IDLE;
    rsp_valid = state == RESP;
    {alu_s_sub, alu_s_fas, alu_s_and, alu_s_or, alu_s_xor, alu_s_not} = exec ? op_sel(op) : 6'b0;
    alu_a = exec ? rda : '0;
    alu_b = exec ? rdb : '0;
    res = rsv ? '0 : op == OP_LDI ? imm : alu_r;
    c = (op == OP_ADD || op == OP_SUB) && alu_cout;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      {op, rd, ra, rb, imm} <= '0;
      {rsp_data, rsp_flags, rsp_err} <= '0;
    end else
      case (state)
        IDLE: if (cmd_valid) begin
          {op, rd, ra, rb, imm} <= {cmd_op, cmd_rd, cmd_ra, cmd_rb, cmd_imm};
          state <= EXEC;
        end
        EXEC: begin
          rsp_data <= res;
          rsp_flags <= {res[15], c, !rsv && res == '0};
          rsp_err <= rsv;
          state <= RESP;
        end
        RESP: if (rsp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
endmodule

// File: doc/alu_seq.md
# alu_seq

Command sequencer that drives the 16-bit ripple ALU's select-line interface. It accepts register-to-register commands over a valid/ready port and holds a small register file. For each command it drives operands and exactly one operation encoding to the ALU for one cycle, captures result and carry, writes back, and returns result plus flags over a valid/ready response port. The ALU is instantiated beside this block in the parent and wired port-to-port.

## Interface
- NREG, 4, register-file depth (power of two, ≥2); AW = log2(NREG)
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous reset, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  block can accept a command
- cmd_op  in  3  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT, 6 LDI, 7 reserved
- cmd_rd / cmd_ra / cmd_rb  in  AW each  destination / operand A / operand B register
- cmd_imm  in  16  immediate (LDI only)
- rsp_valid  out  1  response held
- rsp_ready  in  1  consumer takes response
- rsp_data  out  16  result
- rsp_flags  out  3  {N, C, Z}
- rsp_err  out  1  reserved opcode
- alu_a, alu_b  out  16  ALU operands
- alu_s_sub, alu_s_fas, alu_s_and, alu_s_or, alu_s_xor, alu_s_not  out  1 each  ALU select lines
- alu_r  in  16  ALU result
- alu_cout  in  1  ALU carry out

## Operation
- FSM states: IDLE, EXEC, RESP.
  - IDLE: cmd_ready=1. On cmd_valid&cmd_ready, latch op/rd/ra/rb/imm and go to EXEC.
  - EXEC: drive alu_a=R[ra] and alu_b=R[rb], plus the select encoding. At end of cycle, capture result and flags, write R[rd], and go to RESP.
  - RESP: rsp_valid=1, outputs stable; on rsp_ready go to IDLE.
- Select encoding, driven only in EXEC (all selects 0 otherwise):
  - ADD: s_fas=1, s_sub=0
  - SUB: s_fas=1, s_sub=1
  - AND, OR, XOR, NOT: the single matching line = 1
  - LDI and reserved: all 0
- alu_a and alu_b are 0 outside EXEC.
- Result:
  - ALU ops: alu_r
  - LDI: imm, no ALU use
  - reserved: 0, rsp_err=1, no register write
- Flags:
  - Z = (result==0)
  - N = result[15]
  - C = alu_cout for ADD/SUB, else 0. For SUB, C=1 means no borrow.
  - Reserved opcode: flags = 0.
- Operand reads in EXEC see pre-write contents, so rd may equal ra or rb.
- Write-back completes before the next accept, so dependent back-to-back commands see the new value.
- rsp_err=0 for all defined opcodes.

## Timing
- Accept at edge k. EXEC during cycle k..k+1. Capture and write at edge k+1. rsp_valid=1 from k+1.
- With rsp_ready=1 continuously: response handshake at edge k+2, cmd_ready=1 from k+2. Throughput is one command per 3 cycles.
- cmd_ready=0 in EXEC and RESP. A cmd_valid presented then is not consumed.
- rsp_data, rsp_flags and rsp_err hold unchanged while rsp_valid=1 and rsp_ready=0, for any stall length.
- ALU path is combinational through the ripple chain. The whole EXEC cycle is budgeted for 16-bit carry propagation.
- Reset values:
  - state IDLE, cmd_ready=1 in the cycle after reset
  - rsp_valid=0, rsp_data=0, rsp_flags=0, rsp_err=0
  - all registers 0, all alu_* outputs 0
- rst in EXEC or RESP abandons the command. No write occurs if rst is sampled at the EXEC-exit edge, and no response is delivered.

## Structure
- Package alu_seq_pkg holds:
  - opcode localparams
  - FSM state encoding
  - a function mapping opcode to the 6-bit select vector {sub, fas, and, or, xor, not}
- Sub-module alu_seq_regfile: NREG×16 registers, two combinational read ports, one synchronous write port, cleared by rst.
- FSM, command latch, flag logic and response register live in alu_seq.
- Bench wires the real ALU to the alu_* ports.

## Test plan
- LDI R0,5; LDI R1,7; SUB R2,R0,R1 -> rsp_data=0xFFFE, N=1, C=0, Z=0; alu_s_sub=alu_s_fas=1 for exactly one cycle.
- LDI R0,0xFFFF; LDI R1,1; ADD R2,R0,R1 -> rsp_data=0x0000, Z=1, C=1, N=0.
- R0=0xF0F0, R1=0x0FF0:
  - AND -> 0x00F0
  - OR -> 0xFFF0
  - XOR -> 0xFF00
  - NOT R0 -> 0x0F0F
  - C=0 in all four; only the matching select line rises.
- Opcode 7 -> rsp_err=1, rsp_data=0, flags=0; register file unchanged.
- Hold rsp_ready=0 for 5 cycles -> response stable, cmd_ready=0, a pending cmd_valid is not consumed; accept occurs the cycle after the handshake.
- ADD R0,R0,R0 with R0=3 -> 6; then assert rst during the next command's EXEC -> no write-back, no response, registers read 0 after reset.
